// File: rtl/wash_cycle_timer_if.sv
// Run/pause control and timer status bundle between the washer FSM and wash_cycle_timer.
// The FSM/front-panel side is the master; the timer block is the slave.
interface wash_cycle_timer_if;
    logic       timer_enable;
    logic       pause_req;
    logic [4:0] timer;
    logic       timer_pause;
    logic       minute_tick;
    logic       timer_ovf;
    logic       pause_expired;

    modport master (
        output timer_enable,
        output pause_req,
        input  timer,
        input  timer_pause,
        input  minute_tick,
        input  timer_ovf,
        input  pause_expired
    );

    modport slave (
        input  timer_enable,
        input  pause_req,
        output timer,
        output timer_pause,
        output minute_tick,
        output timer_ovf,
        output pause_expired
    );
endinterface

// File: rtl/wash_cycle_timer.sv
// Minute-tick timebase with pause toggle for the washer sequencer.
// Optional macro WASH_PAUSE_TIMEOUT_EN adds auto-resume after MAX_PAUSE_MIN minutes paused.
module wash_cycle_timer #(
    parameter int CYCLES_PER_MIN = 60,
    parameter int PRESC_W        = 16,
    parameter int TIMER_MAX      = 31,
    parameter int MAX_PAUSE_MIN  = 3
) (
    input  logic               clk,
    input  logic               rst,
    wash_cycle_timer_if.slave  bus
);
    if (CYCLES_PER_MIN < 2 || (64'd1 << PRESC_W) < 64'(CYCLES_PER_MIN)) begin : g_bad_presc
        $error("wash_cycle_timer: invalid CYCLES_PER_MIN/PRESC_W");
    end
    if (TIMER_MAX > 31 || TIMER_MAX < 1 || MAX_PAUSE_MIN < 1) begin : g_bad_limits
        $error("wash_cycle_timer: invalid TIMER_MAX/MAX_PAUSE_MIN");
    end

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, SAT} state_t;

    state_t               state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [4:0]           timer_q, timer_d;
    logic                 timer_pause_q, timer_pause_d;
    logic                 minute_tick_q, minute_tick_d;
    logic                 timer_ovf_q, timer_ovf_d;
    logic                 pause_req_q;
    logic                 pr_edge;
    logic                 wrap;

    assign pr_edge = bus.pause_req & ~pause_req_q;
    assign wrap    = (presc_q == PRESC_W'(CYCLES_PER_MIN - 1));

`ifdef WASH_PAUSE_TIMEOUT_EN
    localparam int PM_W = $clog2(MAX_PAUSE_MIN + 1);
    logic [PRESC_W-1:0] pp_q, pp_d;
    logic [PM_W-1:0]    pm_q, pm_d;
    logic               pause_expired_q, pause_expired_d;
`endif

    always_comb begin
        state_d       = state_q;
        presc_d       = presc_q;
        timer_d       = timer_q;
        minute_tick_d = 1'b0;
        timer_ovf_d   = timer_ovf_q;
`ifdef WASH_PAUSE_TIMEOUT_EN
        pp_d            = '0;
        pm_d            = '0;
        pause_expired_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                timer_d = '0;
                presc_d = '0;
                if (bus.timer_enable) begin
                    state_d     = RUN;
                    timer_ovf_d = 1'b0;
                end
            end
            RUN: begin
                if (wrap) begin
                    presc_d = '0;
                    if (timer_q < 5'(TIMER_MAX)) begin
                        timer_d       = timer_q + 5'd1;
                        minute_tick_d = 1'b1;
                        if (pr_edge) state_d = PAUSED;
                    end else begin
                        timer_ovf_d = 1'b1;
                        state_d     = SAT;
                    end
                end else if (pr_edge) begin
                    // Partial minute is held so resume continues where it left off.
                    state_d = PAUSED;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            PAUSED: begin
                if (pr_edge) begin
                    state_d = RUN;
                end
`ifdef WASH_PAUSE_TIMEOUT_EN
                else if (pp_q == PRESC_W'(CYCLES_PER_MIN - 1)) begin
                    if (pm_q == PM_W'(MAX_PAUSE_MIN - 1)) begin
                        state_d         = RUN;
                        pause_expired_d = 1'b1;
                    end else begin
                        pm_d = pm_q + 1'b1;
                    end
                end else begin
                    pp_d = pp_q + 1'b1;
                    pm_d = pm_q;
                end
`endif
            end
            SAT: begin
                timer_d     = 5'(TIMER_MAX);
                timer_ovf_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (!bus.timer_enable && state_q != IDLE) begin
            state_d       = IDLE;
            timer_d       = '0;
            presc_d       = '0;
            minute_tick_d = 1'b0;
`ifdef WASH_PAUSE_TIMEOUT_EN
            pause_expired_d = 1'b0;
`endif
        end
        timer_pause_d = (state_d == PAUSED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            presc_q       <= '0;
            timer_q       <= '0;
            timer_pause_q <= 1'b0;
            minute_tick_q <= 1'b0;
            timer_ovf_q   <= 1'b0;
            pause_req_q   <= 1'b0;
`ifdef WASH_PAUSE_TIMEOUT_EN
            pp_q            <= '0;
            pm_q            <= '0;
            pause_expired_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            timer_q       <= timer_d;
            timer_pause_q <= timer_pause_d;
            minute_tick_q <= minute_tick_d;
            timer_ovf_q   <= timer_ovf_d;
            pause_req_q   <= bus.pause_req;
`ifdef WASH_PAUSE_TIMEOUT_EN
            pp_q            <= pp_d;
            pm_q            <= pm_d;
            pause_expired_q <= pause_expired_d;
`endif
        end
    end

    assign bus.timer       = timer_q;
    assign bus.timer_pause = timer_pause_q;
    assign bus.minute_tick = minute_tick_q;
    assign bus.timer_ovf   = timer_ovf_q;
`ifdef WASH_PAUSE_TIMEOUT_EN
    assign bus.pause_expired = pause_expired_q;
`else
    assign bus.pause_expired = 1'b0;
`endif
endmodule

// File: tb/tb_wash_cycle_timer.sv
// Scoreboard bench for wash_cycle_timer (CYCLES_PER_MIN=4, TIMER_MAX=31, MAX_PAUSE_MIN=3).
// Stimulus queues expected ticks/expiries with their cycle numbers; a monitor pops on each pulse.
module tb_wash_cycle_timer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        logic [4:0] t;
        int         c;
    } tick_exp_t;

    tick_exp_t tick_q[$];
    int        expire_q[$];

    wash_cycle_timer_if bus();

    wash_cycle_timer #(
        .CYCLES_PER_MIN(4),
        .PRESC_W(16),
        .TIMER_MAX(31),
        .MAX_PAUSE_MIN(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tick(input int t, input int c);
        tick_exp_t e;
        e.t = 5'(t);
        e.c = c;
        tick_q.push_back(e);
    endtask

    // Monitor: every minute_tick / pause_expired pulse is matched against the queues.
    always @(negedge clk) begin
        if (!rst && bus.minute_tick === 1'b1) begin
            if (tick_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_tick at cyc %0d: timer=%0d, no tick expected", cyc, bus.timer);
            end else begin
                tick_exp_t e;
                e = tick_q.pop_front();
                check("tick_timer", int'(bus.timer), int'(e.t));
                check("tick_cycle", cyc, e.c);
                $display("tick: cyc=%0d timer=%0d (expected %0d @ %0d)", cyc, bus.timer, e.t, e.c);
            end
        end
        if (!rst && bus.pause_expired !== 1'b0) begin
            if (expire_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pause_expired at cyc %0d: value=%b required 0", cyc, bus.pause_expired);
            end else begin
                int ec;
                ec = expire_q.pop_front();
                check("expire_cycle", cyc, ec);
                $display("expire: cyc=%0d (expected %0d)", cyc, ec);
            end
        end
    end

    initial begin
        int c0, d, e, f, g, h, r, s;
        bus.timer_enable = 1'b0;
        bus.pause_req    = 1'b0;

        // 1. reset and basic counting
        step(2);
        check("rst_timer", int'(bus.timer), 0);
        check("rst_pause", int'(bus.timer_pause), 0);
        check("rst_tick", int'(bus.minute_tick), 0);
        check("rst_ovf", int'(bus.timer_ovf), 0);
        check("rst_expired", int'(bus.pause_expired), 0);
        rst = 1'b0;
        bus.timer_enable = 1'b1;
        c0 = cyc;
        for (int k = 1; k <= 17; k++) push_tick(k, c0 + 1 + 4 * k);
        step(69);
        check("run_timer17", int'(bus.timer), 17);

        // 2. pause mid-minute (prescaler=2), hold, resume
        step(2);
        bus.pause_req = 1'b1;
        step(1);
        check("pause_set", int'(bus.timer_pause), 1);
        bus.pause_req = 1'b0;
        step(20);
        check("paused_timer", int'(bus.timer), 17);
        check("paused_flag", int'(bus.timer_pause), 1);
        d = cyc;
        push_tick(18, d + 3);
        bus.pause_req = 1'b1;
        step(1);
        check("resume_clr", int'(bus.timer_pause), 0);
        bus.pause_req = 1'b0;
        step(2);

        // 3. disable while paused
        bus.timer_enable = 1'b0;
        step(1);
        check("disable_timer", int'(bus.timer), 0);
        bus.timer_enable = 1'b1;
        e = cyc;
        for (int k = 1; k <= 5; k++) push_tick(k, e + 1 + 4 * k);
        step(21);
        bus.pause_req = 1'b1;
        step(1);
        bus.pause_req = 1'b0;
        check("pause5_flag", int'(bus.timer_pause), 1);
        check("pause5_timer", int'(bus.timer), 5);
        bus.timer_enable = 1'b0;
        step(1);
        check("drop_timer", int'(bus.timer), 0);
        check("drop_pause", int'(bus.timer_pause), 0);
        bus.timer_enable = 1'b1;
        f = cyc;
        push_tick(1, f + 5);
        step(5);
        check("reenable_timer", int'(bus.timer), 1);

        // 4. saturation and overflow
        bus.timer_enable = 1'b0;
        step(1);
        bus.timer_enable = 1'b1;
        g = cyc;
        for (int k = 1; k <= 31; k++) push_tick(k, g + 1 + 4 * k);
        step(125);
        check("sat_timer31", int'(bus.timer), 31);
        step(3);
        check("ovf_before", int'(bus.timer_ovf), 0);
        step(1);
        check("ovf_set", int'(bus.timer_ovf), 1);
        check("ovf_timer", int'(bus.timer), 31);
        bus.pause_req = 1'b1;
        step(1);
        bus.pause_req = 1'b0;
        step(1);
        check("sat_pause_ignored", int'(bus.timer_pause), 0);
        check("sat_timer_held", int'(bus.timer), 31);
        bus.timer_enable = 1'b0;
        step(1);
        check("ovf_sticky", int'(bus.timer_ovf), 1);
        check("idle_timer", int'(bus.timer), 0);
        bus.timer_enable = 1'b1;
        h = cyc;
        for (int k = 1; k <= 4; k++) push_tick(k, h + 1 + 4 * k);
        step(1);
        check("ovf_cleared", int'(bus.timer_ovf), 0);

        // 5. pause request on a wrap cycle
        step(15);
        bus.pause_req = 1'b1;
        step(1);
        bus.pause_req = 1'b0;
        check("wrap_pause_flag", int'(bus.timer_pause), 1);
        check("wrap_pause_timer", int'(bus.timer), 4);
        step(3);
        r = cyc;
        push_tick(5, r + 5);
        bus.pause_req = 1'b1;
        step(1);
        check("wrap_resume", int'(bus.timer_pause), 0);
        bus.pause_req = 1'b0;
        step(4);

        // 6. pause timeout (or indefinite hold without the feature)
        s = cyc;
        bus.pause_req = 1'b1;
        step(1);
        bus.pause_req = 1'b0;
`ifdef WASH_PAUSE_TIMEOUT_EN
        expire_q.push_back(s + 13);
        push_tick(6, s + 17);
        step(11);
        check("timeout_still_paused", int'(bus.timer_pause), 1);
        step(1);
        check("timeout_resumed", int'(bus.timer_pause), 0);
        step(4);
        check("timeout_timer", int'(bus.timer), 6);
`else
        step(100);
        check("hold_paused", int'(bus.timer_pause), 1);
        check("hold_timer", int'(bus.timer), 5);
        check("hold_expired", int'(bus.pause_expired), 0);
`endif

        step(2);
        check("ticks_left", tick_q.size(), 0);
        check("expires_left", expire_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
